// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator and the quarter-wave sine
// table generator used to populate the ROM at elaboration time.
package dds_pkg;

   localparam int DDS_ACC_W = 32;
   localparam int DDS_PH_W  = 10;
   localparam int DDS_OUT_W = 8;
   localparam int STAGES    = 3;

   localparam logic [1:0] WAVE_SINE   = 2'b00;
   localparam logic [1:0] WAVE_SQUARE = 2'b01;
   localparam logic [1:0] WAVE_TRI    = 2'b10;
   localparam logic [1:0] WAVE_SAW    = 2'b11;

   localparam logic [7:0] MIDSCALE = 8'd128;

   localparam longint ONE_Q30 = 64'sd1073741824;
   localparam longint PI_Q30  = 64'sd3373259426;

   // round(127*sin(2*pi*(idx+0.5)/1024)) in Q30 fixed point; Horner form of
   // the Taylor series up to x^15 keeps the error far below the rounding step.
   function automatic logic [6:0] sine_rom_val(input int idx);
      longint x, x2, t, s, v;
      x  = (longint'(2 * idx + 1) * PI_Q30) >>> 10;
      x2 = (x * x) >>> 30;
      t  = ONE_Q30;
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 210);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 156);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 110);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 72);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 42);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 20);
      t  = ONE_Q30 - (((x2 * t) >>> 30) / 6);
      s  = (x * t) >>> 30;
      v  = (127 * s + (ONE_Q30 >>> 1)) >>> 30;
      return 7'(v);
   endfunction

endpackage

// File: rtl/dds_wave_gen_sine_qrom.sv
// 256x7 quarter-wave sine ROM with registered read; forms the sine path's
// second pipeline stage.
module sine_qrom
   import dds_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   output logic [6:0] data
);

   logic [6:0] rom_tbl [256];
   logic [6:0] data_d, data_q;

   for (genvar i = 0; i < 256; i++) begin : g_rom
      assign rom_tbl[i] = sine_rom_val(i);
   end

   always_comb begin
      data_d = rom_tbl[addr];
   end

   always_ff @(posedge clk) begin
      if (rst) data_q <= '0;
      else     data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// Phase accumulator with wrap-synchronous increment/waveform shadowing, and a
// 3-stage sine/square/triangle/sawtooth pipeline feeding an 8-bit DAC.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int ACC_W = DDS_ACC_W,
   parameter int PH_W  = DDS_PH_W,
   parameter int OUT_W = DDS_OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync_clr,
   input  logic [ACC_W-1:0] inc,
   input  logic [1:0]       wave_sel,
   input  logic [PH_W-1:0]  phase_ofs,
   output logic [OUT_W-1:0] wave_out,
   output logic             wave_vld,
   output logic             cycle_tick
);

   logic [ACC_W-1:0] acc_d, acc_q, inc_act_d, inc_act_q, sum;
   logic             carry, issue, load;
   logic [1:0]       wave_act_d, wave_act_q;
   logic             wrap_d, wrap_q;

   logic [STAGES:1]  vld_pipe_d, vld_pipe_q;
   logic [STAGES:1]  tick_pipe_d, tick_pipe_q;

   logic [PH_W-1:0]  ph1_d, ph1_q;
   logic [1:0]       wave1_d, wave1_q, wave2_d, wave2_q;
   logic             half2_d, half2_q;
   logic [OUT_W-1:0] shape2_d, shape2_q;
   logic [OUT_W-1:0] wave_out_d, wave_out_q, sine_val;
   logic [PH_W-3:0]  rom_addr;
   logic [OUT_W-2:0] rom_data;

   // Accumulator and shadow registers: new inc/wave only land at a wrap
   // (or while idle / on clear) so a period is never cut short.
   always_comb begin
      {carry, sum} = {1'b0, acc_q} + {1'b0, inc_act_q};
      issue        = en & ~sync_clr;
      load         = ~en | sync_clr | carry;
      acc_d        = acc_q;
      wrap_d       = wrap_q;
      if (sync_clr) begin
         acc_d  = '0;
         wrap_d = 1'b0;
      end else if (en) begin
         acc_d  = sum;
         wrap_d = carry;
      end
      inc_act_d  = load ? inc      : inc_act_q;
      wave_act_d = load ? wave_sel : wave_act_q;
   end

   // Stage 1: truncated phase plus live offset; tick marks the first phase
   // produced by a carrying addition.
   always_comb begin
      ph1_d       = acc_q[ACC_W-1 -: PH_W] + phase_ofs;
      wave1_d     = wave_act_q;
      vld_pipe_d  = {vld_pipe_q[STAGES-1:1], issue};
      tick_pipe_d = {tick_pipe_q[STAGES-1:1], issue & wrap_q};
   end

   // Stage 2: ROM lookup in parallel with the arithmetic shapes.
   always_comb begin
      rom_addr = ph1_q[PH_W-2] ? ~ph1_q[PH_W-3:0] : ph1_q[PH_W-3:0];
      half2_d  = ph1_q[PH_W-1];
      wave2_d  = wave1_q;
      case (wave1_q)
         WAVE_SQUARE: shape2_d = ph1_q[PH_W-1] ? '0 : '1;
         WAVE_TRI:    shape2_d = ph1_q[PH_W-1] ? ~ph1_q[PH_W-2:1] : ph1_q[PH_W-2:1];
         WAVE_SAW:    shape2_d = ph1_q[PH_W-1:2];
         default:     shape2_d = '0;
      endcase
   end

   sine_qrom u_rom (
      .clk  (clk),
      .rst  (rst),
      .addr (rom_addr),
      .data (rom_data)
   );

   // Stage 3: fold the quarter wave into the lower/upper half and hold the
   // output between valid samples.
   always_comb begin
      sine_val   = half2_q ? (MIDSCALE - 8'd1 - {1'b0, rom_data})
                           : (MIDSCALE + {1'b0, rom_data});
      wave_out_d = wave_out_q;
      if (vld_pipe_q[2]) wave_out_d = (wave2_q == WAVE_SINE) ? sine_val : shape2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         inc_act_q   <= '0;
         wave_act_q  <= WAVE_SINE;
         wrap_q      <= 1'b0;
         vld_pipe_q  <= '0;
         tick_pipe_q <= '0;
         ph1_q       <= '0;
         wave1_q     <= WAVE_SINE;
         wave2_q     <= WAVE_SINE;
         half2_q     <= 1'b0;
         shape2_q    <= '0;
         wave_out_q  <= MIDSCALE;
      end else begin
         acc_q       <= acc_d;
         inc_act_q   <= inc_act_d;
         wave_act_q  <= wave_act_d;
         wrap_q      <= wrap_d;
         vld_pipe_q  <= vld_pipe_d;
         tick_pipe_q <= tick_pipe_d;
         ph1_q       <= ph1_d;
         wave1_q     <= wave1_d;
         wave2_q     <= wave2_d;
         half2_q     <= half2_d;
         shape2_q    <= shape2_d;
         wave_out_q  <= wave_out_d;
      end
   end

   assign wave_out   = wave_out_q;
   assign wave_vld   = vld_pipe_q[STAGES];
   assign cycle_tick = tick_pipe_q[STAGES];

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a behavioural model predicts each sample
// at issue time; a negedge monitor pops and compares whenever wave_vld is seen.
module tb_dds_wave_gen;

   localparam real             PI    = 3.14159265358979323846;
   localparam longint unsigned TWO32 = 64'h1_0000_0000;

   logic        clk = 1'b0;
   logic        rst, en, sync_clr;
   logic [31:0] inc;
   logic [1:0]  wave_sel;
   logic [9:0]  phase_ofs;
   logic [7:0]  wave_out;
   logic        wave_vld, cycle_tick;

   always #5 clk = ~clk;

   dds_wave_gen dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sync_clr   (sync_clr),
      .inc        (inc),
      .wave_sel   (wave_sel),
      .phase_ofs  (phase_ofs),
      .wave_out   (wave_out),
      .wave_vld   (wave_vld),
      .cycle_tick (cycle_tick)
   );

   typedef struct {
      int val;
      bit tick;
      int edge_n;
      int epoch;
   } exp_t;

   exp_t sb[$];
   int   errors = 0, checks = 0;
   int   edge_cnt = 0, rst_events = 0;
   bit   final_req = 1'b0;

   // Reference: waveform shapes straight from their definitions.
   function automatic int ref_sample(input int p, input int w);
      int quad, r, idx, v;
      case (w)
         1: return (p < 512) ? 255 : 0;
         2: return (p < 512) ? p / 2 : 255 - (p - 512) / 2;
         3: return p / 4;
         default: begin
            quad = p / 256;
            r    = p % 256;
            idx  = (quad % 2 == 1) ? 255 - r : r;
            v    = $rtoi(127.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 1024.0) + 0.5);
            return (quad >= 2) ? 127 - v : 128 + v;
         end
      endcase
   endfunction

   longint unsigned m_acc, m_inc, m_nxt;
   int              m_wave, m_p;
   bit              m_wrapped, m_carry;
   exp_t            m_item;

   always @(posedge clk) begin
      edge_cnt++;
      if (rst) begin
         m_acc     = 0;
         m_inc     = 0;
         m_wave    = 0;
         m_wrapped = 1'b0;
         rst_events++;
      end else begin
         m_nxt   = m_acc + m_inc;
         m_carry = (m_nxt >= TWO32);
         if (en && !sync_clr) begin
            m_p          = int'(((m_acc >> 22) + longint'(phase_ofs)) % 1024);
            m_item.val   = ref_sample(m_p, m_wave);
            m_item.tick  = m_wrapped;
            m_item.edge_n = edge_cnt;
            m_item.epoch = rst_events;
            sb.push_back(m_item);
         end
         if (sync_clr) begin
            m_acc     = 0;
            m_wrapped = 1'b0;
         end else if (en) begin
            m_acc     = m_nxt % TWO32;
            m_wrapped = m_carry;
         end
         if (!en || sync_clr || m_carry) begin
            m_inc  = longint'(inc);
            m_wave = int'(wave_sel);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   int   seen_rst = 0;
   int   hold_exp = 128;
   exp_t mon_item;

   always @(negedge clk) begin
      if (rst_events != 0) begin
         if (seen_rst != rst_events) begin
            seen_rst = rst_events;
            hold_exp = 128;
         end
         while (sb.size() > 0 && sb[0].epoch != rst_events) void'(sb.pop_front());
         while (sb.size() > 0 && sb[0].edge_n + 2 < edge_cnt) begin
            check("missing_sample", 0, 1);
            void'(sb.pop_front());
         end
         if (wave_vld) begin
            if (sb.size() == 0) begin
               check("unexpected_vld", 1, 0);
            end else begin
               mon_item = sb.pop_front();
               check("latency", edge_cnt, mon_item.edge_n + 2);
               check("wave_out", int'(wave_out), mon_item.val);
               check("cycle_tick", int'(cycle_tick), int'(mon_item.tick));
               hold_exp = mon_item.val;
            end
         end else begin
            check("hold_out", int'(wave_out), hold_exp);
            check("idle_tick", int'(cycle_tick), 0);
         end
         if (final_req) check("drain_empty", sb.size(), 0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sync_clr = 1'b0;
      inc = 32'h4000_0000; wave_sel = 2'b11; phase_ofs = '0;
      repeat (3) cyc();
      rst = 1'b0;
      en = 1'b1; sync_clr = 1'b1;
      cyc();
      sync_clr = 1'b0;
      repeat (12) cyc();

      for (int s = 0; s < 3; s++) begin
         wave_sel = 2'(s);
         repeat (12) cyc();
      end

      wave_sel = 2'b11; phase_ofs = 10'd256;
      repeat (10) cyc();
      phase_ofs = '0;

      sync_clr = 1'b1;
      cyc();
      sync_clr = 1'b0;
      cyc();
      inc = 32'h2000_0000;
      repeat (16) cyc();

      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; en = 1'b0; inc = 32'h4000_0000;
      cyc();
      en = 1'b1;
      repeat (8) cyc();

      inc = 32'h0100_0000; en = 1'b0;
      cyc();
      en = 1'b1;
      repeat (4) cyc();
      en = 1'b0; inc = 32'h0200_0000;
      repeat (3) cyc();
      en = 1'b1;
      repeat (6) cyc();

      en = 1'b0; inc = '0;
      cyc();
      en = 1'b1;
      repeat (6) cyc();

      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         sync_clr = ($urandom_range(0, 29) == 0);
         en       = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       inc = $urandom;
               1:       inc = {4'($urandom_range(1, 15)), 28'($urandom)};
               2:       inc = 32'($urandom_range(0, 3)) << 30;
               default: inc = '0;
            endcase
         end
         if ($urandom_range(0, 9) == 0) wave_sel  = 2'($urandom);
         if ($urandom_range(0, 9) == 0) phase_ofs = 10'($urandom);
         cyc();
      end

      rst = 1'b0; sync_clr = 1'b0; en = 1'b0;
      repeat (6) cyc();
      final_req = 1'b1;
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
